// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb: merges the MMU fetch port and load/store port onto one
// in-order external memory bus. An order FIFO remembers which port issued
// each bus request so responses are routed back (with the LS tag restored).
// Fetch responses that were in flight across a fetch flush/invalidate are
// dropped.
module riscv_mem_arb #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        mem_if_rd,
  input  logic [31:0] mem_if_pc,
  input  logic        mem_if_flush,
  input  logic        mem_if_inval,
  output logic        mem_if_accept,
  output logic        mem_if_valid,
  output logic        mem_if_error,
  output logic [31:0] mem_if_inst,
  // load/store port
  input  logic [31:0] mem_ls_addr,
  input  logic [31:0] mem_ls_wdata,
  input  logic        mem_ls_rd,
  input  logic [3:0]  mem_ls_wr,
  input  logic        mem_ls_cacheable,
  input  logic [10:0] mem_ls_req_tag,
  input  logic        mem_ls_inval,
  input  logic        mem_ls_wb,
  input  logic        mem_ls_flush,
  output logic        mem_ls_accept,
  output logic        mem_ls_ack,
  output logic        mem_ls_error,
  output logic [31:0] mem_ls_rdata,
  output logic [10:0] mem_ls_resp_tag,
  // external bus
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_we,
  output logic        bus_cacheable,
  input  logic        bus_accept,
  input  logic        bus_resp_valid,
  input  logic        bus_resp_error,
  input  logic [31:0] bus_rdata,
  // sticky: a bus response arrived with nothing outstanding
  output logic        o_dbg_unexp_resp
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_LS = 1'b1;

  // Pointer advance with explicit wrap so non-power-of-two widths stay safe.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? PW'(0) : p + PW'(1);
  endfunction

  // order FIFO storage
  logic          r_fifo_src  [MAX_OUTSTANDING];
  logic          r_fifo_disc [MAX_OUTSTANDING];
  logic [10:0]   r_fifo_tag  [MAX_OUTSTANDING];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  // arbitration / lock state
  logic        r_last_grant;
  logic        r_lock;
  logic        r_lock_ls;
  logic        r_lock_disc;
  logic [31:0] r_lk_addr, r_lk_wdata;
  logic [3:0]  r_lk_we;
  logic        r_lk_cache;
  logic [10:0] r_lk_tag;

  // response registers
  logic        r_if_valid, r_if_error, r_ls_ack, r_ls_error, r_unexp;
  logic [31:0] r_if_inst, r_ls_rdata;
  logic [10:0] r_ls_tag;

  logic        w_if_req, w_ls_req, w_ls_maint, w_if_flush;
  logic        w_slot_free, w_grant, w_sel_ls;
  logic        w_push, w_pop, w_maint_acc, w_push_disc;
  logic [31:0] w_req_addr, w_req_wdata;
  logic [3:0]  w_req_we;
  logic        w_req_cache;
  logic [10:0] w_req_tag;
  logic        w_head_src, w_head_disc;
  logic [10:0] w_head_tag;

  assign w_if_req    = mem_if_rd;
  assign w_ls_req    = mem_ls_rd | (|mem_ls_wr);
  assign w_ls_maint  = (mem_ls_inval | mem_ls_wb | mem_ls_flush) & ~w_ls_req;
  assign w_if_flush  = mem_if_flush | mem_if_inval;
  assign w_slot_free = (r_count < DEPTH_C) & ~r_lock;

  // Grant selection: a locked request keeps the bus, otherwise round-robin on ties.
  always_comb begin
    w_grant  = 1'b0;
    w_sel_ls = SRC_IF;
    if (r_lock) begin
      w_grant  = 1'b1;
      w_sel_ls = r_lock_ls;
    end else if (w_slot_free) begin
      if (w_if_req && w_ls_req) begin
        w_grant  = 1'b1;
        w_sel_ls = ~r_last_grant;
      end else if (w_ls_req) begin
        w_grant  = 1'b1;
        w_sel_ls = SRC_LS;
      end else if (w_if_req) begin
        w_grant  = 1'b1;
        w_sel_ls = SRC_IF;
      end else begin
        w_grant  = 1'b0;
        w_sel_ls = SRC_IF;
      end
    end else begin
      w_grant  = 1'b0;
      w_sel_ls = SRC_IF;
    end
  end

  // Request mux: live source fields, or the captured copy while locked.
  always_comb begin
    w_req_addr  = 32'h0000_0000;
    w_req_wdata = 32'h0000_0000;
    w_req_we    = 4'h0;
    w_req_cache = 1'b0;
    w_req_tag   = 11'h000;
    if (!w_grant) begin
      w_req_addr  = 32'h0000_0000;
    end else if (r_lock) begin
      w_req_addr  = r_lk_addr;
      w_req_wdata = r_lk_wdata;
      w_req_we    = r_lk_we;
      w_req_cache = r_lk_cache;
      w_req_tag   = r_lk_tag;
    end else if (w_sel_ls == SRC_LS) begin
      w_req_addr  = mem_ls_addr;
      w_req_wdata = mem_ls_wdata;
      w_req_we    = mem_ls_wr;
      w_req_cache = mem_ls_cacheable;
      w_req_tag   = mem_ls_req_tag;
    end else begin
      w_req_addr  = mem_if_pc;
      w_req_cache = 1'b1;
    end
  end

  assign bus_req       = w_grant;
  assign bus_addr      = w_req_addr;
  assign bus_wdata     = w_req_wdata;
  assign bus_we        = w_req_we;
  assign bus_cacheable = w_req_cache;

  // Maintenance ops never touch the bus; they wait for a quiet, empty pipe.
  assign w_maint_acc   = w_ls_maint & (r_count == CW'(0)) & ~r_lock;
  assign mem_if_accept = w_grant & (w_sel_ls == SRC_IF) & bus_accept;
  assign mem_ls_accept = (w_grant & (w_sel_ls == SRC_LS) & bus_accept) | w_maint_acc;

  assign w_push      = w_grant & bus_accept;
  assign w_pop       = bus_resp_valid & (r_count != CW'(0));
  // A fetch held locked across a flush belongs to the old stream.
  assign w_push_disc = (w_sel_ls == SRC_IF) & r_lock & r_lock_disc;

  assign w_head_src  = r_fifo_src[r_rd_ptr];
  assign w_head_disc = r_fifo_disc[r_rd_ptr] | w_if_flush;
  assign w_head_tag  = r_fifo_tag[r_rd_ptr];

  // Lock tracking: capture the request while unlocked, hold it while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock      <= 1'b0;
      r_lock_ls   <= SRC_IF;
      r_lock_disc <= 1'b0;
      r_lk_addr   <= 32'h0000_0000;
      r_lk_wdata  <= 32'h0000_0000;
      r_lk_we     <= 4'h0;
      r_lk_cache  <= 1'b0;
      r_lk_tag    <= 11'h000;
    end else begin
      r_lock      <= w_grant & ~bus_accept;
      r_lock_disc <= w_grant & ~bus_accept & (w_sel_ls == SRC_IF) & r_lock &
                     (r_lock_disc | w_if_flush);
      if (!r_lock) begin
        r_lock_ls  <= w_sel_ls;
        r_lk_addr  <= w_req_addr;
        r_lk_wdata <= w_req_wdata;
        r_lk_we    <= w_req_we;
        r_lk_cache <= w_req_cache;
        r_lk_tag   <= w_req_tag;
      end
    end
  end

  // Round-robin history: remember which source last reached the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SRC_IF;
    end else if (w_push) begin
      r_last_grant <= w_sel_ls;
    end
  end

  // Order FIFO entries: flush marks pre-edge fetch entries, push writes the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo_src[i]  <= SRC_IF;
        r_fifo_disc[i] <= 1'b0;
        r_fifo_tag[i]  <= 11'h000;
      end
    end else begin
      if (w_if_flush) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          if (r_fifo_src[i] == SRC_IF) begin
            r_fifo_disc[i] <= 1'b1;
          end
        end
      end
      if (w_push) begin
        r_fifo_src[r_wr_ptr]  <= w_sel_ls;
        r_fifo_disc[r_wr_ptr] <= w_push_disc;
        r_fifo_tag[r_wr_ptr]  <= (w_sel_ls == SRC_LS) ? w_req_tag : 11'h000;
      end
    end
  end

  // Order FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response routing: one-cycle pulses to the port named by the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_error <= 1'b0;
      r_if_inst  <= 32'h0000_0000;
      r_ls_ack   <= 1'b0;
      r_ls_error <= 1'b0;
      r_ls_rdata <= 32'h0000_0000;
      r_ls_tag   <= 11'h000;
      r_unexp    <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_ls_ack   <= 1'b0;
      if (bus_resp_valid && (r_count == CW'(0))) begin
        r_unexp <= 1'b1;
      end
      if (w_pop) begin
        if (w_head_src == SRC_LS) begin
          r_ls_ack   <= 1'b1;
          r_ls_tag   <= w_head_tag;
          r_ls_rdata <= bus_rdata;
          r_ls_error <= bus_resp_error;
        end else if (!w_head_disc) begin
          r_if_valid <= 1'b1;
          r_if_inst  <= bus_rdata;
          r_if_error <= bus_resp_error;
        end
      end else if (w_maint_acc) begin
        r_ls_ack   <= 1'b1;
        r_ls_tag   <= mem_ls_req_tag;
        r_ls_rdata <= 32'h0000_0000;
        r_ls_error <= 1'b0;
      end
    end
  end

  assign mem_if_valid     = r_if_valid;
  assign mem_if_error     = r_if_error;
  assign mem_if_inst      = r_if_inst;
  assign mem_ls_ack       = r_ls_ack;
  assign mem_ls_error     = r_ls_error;
  assign mem_ls_rdata     = r_ls_rdata;
  assign mem_ls_resp_tag  = r_ls_tag;
  assign o_dbg_unexp_resp = r_unexp;

endmodule

// File: doc/riscv_mem_arb.md
# riscv_mem_arb

Two-port to one-port memory arbiter sitting directly downstream of the MMU. It merges the MMU's translated instruction-fetch port (`mem_if_*`) and load/store port (`mem_ls_*`, which includes page-table-walk reads) onto a single in-order external memory bus. It tracks outstanding transactions in an order FIFO and routes each bus response back to the port that issued it, restoring the LS tag. Fetch responses that are still in flight when a fetch flush or invalidate occurs are discarded.

## Interface
- `MAX_OUTSTANDING`, 2, depth of the order FIFO. Power of two, range 1..8.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_if_rd` in 1 / `mem_if_pc` in 32: fetch request and physical PC.
- `mem_if_flush`, `mem_if_inval` in 1: fetch flush and invalidate.
- `mem_if_accept` out 1: fetch request accepted.
- `mem_if_valid`, `mem_if_error` out 1 / `mem_if_inst` out 32: fetch response.
- `mem_ls_addr`, `mem_ls_wdata` in 32 / `mem_ls_rd` in 1 / `mem_ls_wr` in 4 / `mem_ls_cacheable` in 1 / `mem_ls_req_tag` in 11: LS request.
- `mem_ls_inval`, `mem_ls_wb`, `mem_ls_flush` in 1: cache-maintenance ops.
- `mem_ls_accept` out 1: LS request accepted.
- `mem_ls_ack`, `mem_ls_error` out 1 / `mem_ls_rdata` out 32 / `mem_ls_resp_tag` out 11: LS response.
- `bus_req` out 1 / `bus_addr`, `bus_wdata` out 32 / `bus_we` out 4 / `bus_cacheable` out 1: bus request. `bus_we==0` means a read.
- `bus_accept` in 1: bus accepts the request this cycle.
- `bus_resp_valid`, `bus_resp_error` in 1 / `bus_rdata` in 32: bus response, strictly in request order.

## Operation
- **Sources.**
  - IF request = `mem_if_rd`.
  - LS request = `mem_ls_rd | (|mem_ls_wr)`.
  - LS maintenance = `mem_ls_inval | mem_ls_wb | mem_ls_flush` with no rd/wr.
  - Upstream holds requests stable until accepted.
- **Grant.** Allowed only when FIFO count < `MAX_OUTSTANDING` and the bus is not locked.
  - If only one source requests, it wins.
  - If both request, round-robin on a 1-bit `last_grant` register (reset = IF, so LS wins the first tie).
- **Lock.** While `bus_req & ~bus_accept`, the granted source and all `bus_*` request outputs stay frozen. New grants are blocked until `bus_accept`.
- **Request path.** `bus_*` is driven combinationally from the granted source.
  - `mem_X_accept = granted_X & bus_accept`; the other port's accept is 0.
  - Fetch requests drive `bus_we = 0` and `bus_cacheable = 1`.
- **Order FIFO push** on `bus_req & bus_accept`. Each entry is {src, discard = 0, tag[10:0]}; IF entries use tag 0.
- **FIFO pop** on `bus_resp_valid`. The response is routed by the head entry:
  - LS head: `mem_ls_ack=1`, `mem_ls_resp_tag=tag`, `mem_ls_rdata=bus_rdata`, `mem_ls_error=bus_resp_error`. Writes are also acked.
  - IF head with discard = 0: `mem_if_valid=1`, `mem_if_inst=bus_rdata`, `mem_if_error=bus_resp_error`.
  - IF head with discard = 1: popped silently; no output asserted.
- **Maintenance.**
  - Accepted (`mem_ls_accept=1`, no bus request) only when the FIFO is empty and the bus is unlocked.
  - Acked one cycle later with `mem_ls_resp_tag = req_tag`, `mem_ls_error=0`, `mem_ls_rdata=0`.
- **Fetch flush.**
  - `mem_if_flush | mem_if_inval` at an edge sets discard on every IF entry present before that edge.
  - A fetch accepted in the same cycle is pushed with discard = 0, because it is the new PC.
  - A locked-but-unaccepted fetch completes normally on the bus; it is pushed with discard = 1 if a flush occurred while it was locked.
- **Unexpected response.** `bus_resp_valid` while the FIFO is empty is ignored. A sticky internal flag is set for verification.

## Timing
- **Reset values.** `rst_n` low clears the FIFO, count, lock, `last_grant` (IF), maintenance-pending and all response registers. Every output is 0 during and after reset, except request outputs, which are combinationally 0 with no requests present.
- **Request latency.** 0 cycles: `bus_req` and `accept` follow the inputs combinationally.
- **Response latency.** Registered, 1 cycle: `bus_resp_valid` at edge N gives `mem_*_valid/ack` high during cycle N+1 for exactly one cycle.
- **Simultaneous push and pop** in one cycle: count is unchanged. A push is only allowed if count < depth *before* the edge, so pushing at full is not allowed even when a pop happens in the same cycle.
- **Wrap-around.** Read and write pointers are log2(depth) bits and wrap mod depth. Count is log2(depth)+1 bits and runs 0..depth.
- **Reset mid-transaction.** In-flight responses are lost. Any bus responses arriving after reset are ignored by the empty-FIFO rule.
- **Flush and response together.** A flush in the same cycle as an IF response pop: that response is still discarded if it was in the FIFO before the edge, i.e. the flush is evaluated on pre-edge contents.

## Test plan
- **LS read.** LS read of 0x80000010 with tag 0x3A5; bus accepts immediately and returns 0xDEADBEEF 3 cycles later → `mem_ls_ack` one cycle after `bus_resp_valid`, `resp_tag`=0x3A5, `rdata`=0xDEADBEEF.
- **Round-robin.** IF and LS request every cycle with `bus_accept`=1 → grants alternate LS, IF, LS, IF. Count stops at 2 (`MAX_OUTSTANDING`=2) and pushes stall until a pop.
- **Lock.** `bus_accept` held low for 4 cycles with an IF request, then LS asserts → `bus_addr` stays at the PC for all 4 cycles; LS is granted only after the IF accept.
- **Flush discard.** Two fetches outstanding, `mem_if_flush` pulse, then a new fetch at 0x80001000 → the two old responses produce no `mem_if_valid`; the third asserts `mem_if_valid` with its data.
- **Maintenance.** `mem_ls_flush` with tag 0x7FF while one LS read is outstanding → not accepted until that read's response pops; acked the following cycle, no `bus_req`.
- **Reset mid-transaction.** `rst_n` low during a locked request → all outputs 0. A stale `bus_resp_valid` after reset causes no `mem_if_valid` or `mem_ls_ack`.
